// File: rtl/rv32_multicycle_datapath_if.sv
// Instruction-fetch and data-access handshake bundle for the multicycle core.
// Latency: none; wires only.
// Backpressure: the requester holds req/address/data until ready is seen high.
interface rv32_multicycle_datapath_if;
  logic        iReq;
  logic [31:0] iAddr;
  logic        iReady;
  logic [31:0] instr;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic        dReady;
  logic [31:0] dReadData;

  modport master (
    output iReq, iAddr, dReq, dWe, dAddress, dWriteData,
    input  iReady, instr, dReady, dReadData
  );

  modport slave (
    input  iReq, iAddr, dReq, dWe, dAddress, dWriteData,
    output iReady, instr, dReady, dReadData
  );
endinterface

// File: rtl/rv32_multicycle_datapath.sv
// Multicycle RV32I core (ALU, LW, SW, branches) with a five-state sequencer and trap-to-HALT.
// Latency: branch 3, ALU 4, store 4, load 5 cycles, plus one per memory wait cycle.
// Backpressure: FETCH/MEM stall while iReady/dReady are low; requests stay stable until accepted.
module rv32_multicycle_datapath #(
  parameter logic [31:0] INITIAL_PC = 32'h00400000,
  parameter int          REGCOUNT   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  rv32_multicycle_datapath_if.master   bus,
  output logic [31:0]                  PC,
  output logic [31:0]                  WriteBackData,
  output logic                         retire,
  output logic                         halted
);
  localparam int RW = $clog2(REGCOUNT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_out_q, mdr_q, wbd_q;
  logic [31:0] rf_q [REGCOUNT];

  // Decode fields always come from the latched IR, so every state sees the same instruction.
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [RW-1:0] rs1, rs2, rd;
  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign rd     = ir_q[7 +: RW];
  assign rs1    = ir_q[15 +: RW];
  assign rs2    = ir_q[20 +: RW];

  logic is_r, is_imm, is_load, is_store, is_branch, is_mem;
  assign is_r      = (opcode == OP_R);
  assign is_imm    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_mem    = is_load | is_store;

  // Legality: only funct7 = 0100000 variants that exist (SUB, SRA, SRAI) are accepted.
  logic legal;
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:      legal = (funct7 == 7'h00) ||
                         (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      OP_IMM:    if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
                 else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                 else                       legal = 1'b1;
      OP_LOAD,
      OP_STORE:  legal = (funct3 == 3'b010);
      OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      default:   legal = 1'b0;
    endcase
  end

  logic [31:0] imm_i, imm_s, imm_b, imm_dec;
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_dec = is_store ? imm_s : (is_branch ? imm_b : imm_i);

  // Shared ALU: second operand is B for R-type, IMM otherwise; funct7[5] picks SUB/SRA.
  logic [31:0] op_b, alu_res, addr_sum, br_target;
  logic [4:0]  shamt;
  logic        taken, addr_misalign, br_misalign;
  assign op_b  = is_r ? b_q : imm_q;
  assign shamt = op_b[4:0];
  always_comb begin
    alu_res = 32'h0;
    case (funct3)
      3'b000: alu_res = (is_r && funct7[5]) ? (a_q - op_b) : (a_q + op_b);
      3'b001: alu_res = a_q << shamt;
      3'b010: alu_res = {31'h0, $signed(a_q) < $signed(op_b)};
      3'b011: alu_res = {31'h0, a_q < op_b};
      3'b100: alu_res = a_q ^ op_b;
      3'b101: alu_res = funct7[5] ? 32'($signed(a_q) >>> shamt) : (a_q >> shamt);
      3'b110: alu_res = a_q | op_b;
      default: alu_res = a_q & op_b;
    endcase
  end

  // Branch condition from A/B; target resolved in EXEC using the shared adder inputs.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (a_q == b_q);
      3'b001:  taken = (a_q != b_q);
      3'b100:  taken = ($signed(a_q) <  $signed(b_q));
      3'b101:  taken = ($signed(a_q) >= $signed(b_q));
      3'b110:  taken = (a_q <  b_q);
      3'b111:  taken = (a_q >= b_q);
      default: taken = 1'b0;
    endcase
  end
  assign addr_sum      = a_q + imm_q;
  assign br_target     = taken ? (pc_q + imm_q) : (pc_q + 32'd4);
  assign addr_misalign = (addr_sum[1:0] != 2'b00);
  assign br_misalign   = (br_target[1:0] != 2'b00);

  logic [31:0] wb_val;
  assign wb_val = is_load ? mdr_q : alu_out_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state sequencing, including the traps into HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.iReady) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_branch)   state_d = br_misalign ? S_HALT : S_FETCH;
        else if (is_mem) state_d = addr_misalign ? S_HALT : S_MEM;
        else             state_d = S_WB;
      end
      S_MEM:    if (bus.dReady) state_d = is_load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // Outputs decoded from state; reset masks requests and status in the same cycle.
  always_comb begin
    bus.iReq       = !rst && (state_q == S_FETCH);
    bus.dReq       = !rst && (state_q == S_MEM);
    bus.iAddr      = pc_q;
    bus.dWe        = is_store;
    bus.dAddress   = alu_out_q;
    bus.dWriteData = b_q;
    halted         = !rst && (state_q == S_HALT);
    retire         = 1'b0;
    if (!rst) begin
      case (state_q)
        S_EXEC:  retire = is_branch && !br_misalign;
        S_MEM:   retire = bus.dReady && is_store;
        S_WB:    retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  // Datapath registers and register file, updated according to the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= INITIAL_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      wbd_q     <= '0;
      for (int i = 0; i < REGCOUNT; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH:  if (bus.iReady) ir_q <= bus.instr;
        S_DECODE: begin
          a_q   <= (rs1 == '0) ? 32'h0 : rf_q[rs1];
          b_q   <= (rs2 == '0) ? 32'h0 : rf_q[rs2];
          imm_q <= imm_dec;
        end
        S_EXEC: begin
          if (is_branch) begin
            if (!br_misalign) pc_q <= br_target;
          end else begin
            alu_out_q <= is_mem ? addr_sum : alu_res;
          end
        end
        S_MEM: if (bus.dReady) begin
          if (is_load) mdr_q <= bus.dReadData;
          else         pc_q  <= pc_q + 32'd4;
        end
        S_WB: begin
          if (rd != '0) rf_q[rd] <= wb_val;
          wbd_q <= wb_val;
          pc_q  <= pc_q + 32'd4;
        end
        default: ;
      endcase
    end
  end

  assign PC            = pc_q;
  assign WriteBackData = wbd_q;
endmodule
